leitor_amostras: RTL and testbench
==================================

LEITOR_AMOSTRAS -- requirements
Module: leitor_amostras

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the sample width in bits.
REQ-002 The module SHALL have parameter TIMEOUT_CICLOS, default 255, giving the maximum number of cycles to wait for mem_ack (range 1..255).
REQ-003 The module SHALL have parameter SILENCIO, default 8'h80, giving the mid-scale sample value (DATA_WIDTH bits).
REQ-004 The module SHALL have port clk  input  1  system clock, with all logic on the rising edge.
REQ-005 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port endereco  input  22  word address within the current music, from the address state machine.
REQ-007 The module SHALL have port musica  input  2  music index, used as the upper address bits.
REQ-008 The module SHALL have port addr_valid  input  1  one-cycle pulse requesting a fetch of {musica, endereco}.
REQ-009 The module SHALL have port mem_ack  input  1  memory acknowledge, meaning mem_data is valid in the same cycle.
REQ-010 The module SHALL have port mem_data  input  DATA_WIDTH  read data from memory.
REQ-011 The module SHALL have port mem_addr  output  24  registered read address.
REQ-012 The module SHALL have port mem_req  output  1  registered read request.
REQ-013 The module SHALL have port amostra  output  DATA_WIDTH  registered sample delivered to the audio output.
REQ-014 The module SHALL have port amostra_valid  output  1  one-cycle pulse when amostra is updated.
REQ-015 The module SHALL have port ocupado  output  1  high whenever the FSM is not in OCIOSO.
REQ-016 The module SHALL have port erro_timeout  output  1  one-cycle pulse when a request is abandoned.

Function
REQ-017 The FSM SHALL have exactly three states: OCIOSO, REQUISITA and ENTREGA.
REQ-018 In OCIOSO, on addr_valid or a set pending flag, the FSM SHALL load mem_addr with {musica, endereco} (or the pending address), set mem_req, clear the timeout counter, and go to REQUISITA on the next edge.
REQ-019 mem_req SHALL rise exactly one cycle after addr_valid is sampled when the FSM is in OCIOSO.
REQ-020 In REQUISITA, mem_req and mem_addr SHALL stay stable until mem_ack is sampled high.
REQ-021 On a mem_ack edge, the module SHALL capture mem_data into amostra, drop mem_req, and go to ENTREGA.
REQ-022 In ENTREGA, amostra_valid SHALL be high for exactly one cycle and the FSM SHALL return to OCIOSO, so amostra_valid rises one cycle after the mem_ack edge.
REQ-023 In REQUISITA, the timeout counter SHALL increment every cycle without ack, and reaching TIMEOUT_CICLOS SHALL drop mem_req, pulse erro_timeout and apply REQ-030 or REQ-031 before returning to OCIOSO.
REQ-024 When addr_valid arrives while ocupado is high, the module SHALL latch {musica, endereco} into a one-deep pending register and set the pending flag; a newer addr_valid SHALL overwrite the pending entry (newest wins, older entries are dropped silently).
REQ-025 When addr_valid coincides with the FSM return to OCIOSO, the new address SHALL become pending and SHALL be served with no lost cycle beyond REQ-018.
REQ-026 Changes on musica or endereco while in REQUISITA SHALL NOT affect mem_addr.
REQ-027 mem_ack sampled while the FSM is outside REQUISITA SHALL be ignored.

Reset
REQ-028 While reset is low, the module SHALL hold: FSM in OCIOSO, mem_req=0, mem_addr=0, amostra=SILENCIO, amostra_valid=0, ocupado=0, erro_timeout=0, pending flag=0, timeout counter=0.
REQ-029 A reset asserted mid-request SHALL drop mem_req asynchronously, and no amostra_valid or erro_timeout SHALL follow it.

Configuration
REQ-030 With macro LEITOR_AMOSTRAS_SILENCIO_EN defined, a timeout SHALL load amostra=SILENCIO and pulse amostra_valid in the cycle after erro_timeout (through ENTREGA).
REQ-031 Without LEITOR_AMOSTRAS_SILENCIO_EN, a timeout SHALL leave amostra unchanged, produce no amostra_valid, and return the FSM directly to OCIOSO.

Verification
REQ-032 The bench SHALL cover a basic read: musica=2, endereco=22'h00BB8, addr_valid pulse, mem_ack after 3 cycles with mem_data=8'h5A -> mem_addr=24'h800BB8, mem_req high for 4 cycles, amostra=8'h5A with amostra_valid one cycle after the ack.
REQ-033 The bench SHALL cover back-to-back requests: addresses 10, 11 and 12 pulsed on consecutive cycles with the first ack after 5 cycles -> exactly two reads, at 10 then 12, and address 11 never appears on mem_addr.
REQ-034 The bench SHALL cover a timeout with TIMEOUT_CICLOS=4 and no ack -> mem_req drops after 4 cycles, erro_timeout pulses, and amostra=8'h80 with a valid pulse when the macro is defined, or amostra holds its old value with no valid pulse when it is not.
REQ-035 The bench SHALL cover reset mid-request: reset low 2 cycles after mem_req rises -> mem_req=0 immediately, amostra=8'h80, and no pulse on any output after release.
REQ-036 The bench SHALL cover a stray ack: mem_ack high in OCIOSO with mem_data=8'hFF -> amostra unchanged and amostra_valid=0.

Source files
------------

// File: rtl/leitor_amostras.sv
// Sample reader: turns {musica, endereco} requests into single memory reads with ack timeout.
// Optional macro LEITOR_AMOSTRAS_SILENCIO_EN: a timed-out read delivers SILENCIO as a valid sample.
module leitor_amostras #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           TIMEOUT_CICLOS = 255,
  parameter logic [DATA_WIDTH-1:0] SILENCIO       = 8'h80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [21:0]           endereco,
  input  logic [1:0]            musica,
  input  logic                  addr_valid,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [23:0]           mem_addr,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] amostra,
  output logic                  amostra_valid,
  output logic                  ocupado,
  output logic                  erro_timeout
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    REQUISITA,
    ENTREGA
  } estado_t;

  estado_t           estado;
  logic [CNT_W-1:0]  contador;
  logic              pendente;
  logic [ADDR_W-1:0] end_pendente;
  logic [ADDR_W-1:0] end_novo;
`ifdef LEITOR_AMOSTRAS_SILENCIO_EN
  logic              por_timeout;
`endif

  assign end_novo = {musica, endereco};

  // Request FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado        <= OCIOSO;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      amostra       <= SILENCIO;
      amostra_valid <= 1'b0;
      ocupado       <= 1'b0;
      erro_timeout  <= 1'b0;
      pendente      <= 1'b0;
      end_pendente  <= '0;
      contador      <= '0;
`ifdef LEITOR_AMOSTRAS_SILENCIO_EN
      por_timeout   <= 1'b0;
`endif
    end else begin
      amostra_valid <= 1'b0;
      erro_timeout  <= 1'b0;

      // Requests arriving while busy collapse into one slot; the newest one wins.
      if (addr_valid && (estado != OCIOSO)) begin
        pendente     <= 1'b1;
        end_pendente <= end_novo;
      end

      case (estado)
        OCIOSO: begin
          if (addr_valid || pendente) begin
            mem_addr <= addr_valid ? end_novo : end_pendente;
            mem_req  <= 1'b1;
            contador <= '0;
            pendente <= 1'b0;
            ocupado  <= 1'b1;
            estado   <= REQUISITA;
          end
        end

        REQUISITA: begin
          if (mem_ack) begin
            amostra <= mem_data;
            mem_req <= 1'b0;
            estado  <= ENTREGA;
          end else if (contador == CNT_LIMITE) begin
            mem_req      <= 1'b0;
            erro_timeout <= 1'b1;
`ifdef LEITOR_AMOSTRAS_SILENCIO_EN
            por_timeout  <= 1'b1;
            estado       <= ENTREGA;
`else
            ocupado      <= 1'b0;
            estado       <= OCIOSO;
`endif
          end else begin
            contador <= contador + CNT_W'(1);
          end
        end

        ENTREGA: begin
          amostra_valid <= 1'b1;
          ocupado       <= 1'b0;
          estado        <= OCIOSO;
`ifdef LEITOR_AMOSTRAS_SILENCIO_EN
          if (por_timeout) begin
            amostra <= SILENCIO;
          end
          por_timeout <= 1'b0;
`endif
        end

        default: begin
          estado  <= OCIOSO;
          mem_req <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_amostras.sv
// Bench for leitor_amostras: random requests against a queue-based model, plus directed timeout/reset cases.
`timescale 1ns/1ps
module tb_leitor_amostras;

  localparam int unsigned T_MAIN  = 8;
  localparam int unsigned T_CURTO = 4;
  localparam logic [7:0]  SIL     = 8'h80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance
  logic        reset, addr_valid, resp_ack, stray_ack, mem_ack;
  logic [21:0] endereco;
  logic [1:0]  musica;
  logic [7:0]  resp_data, stray_data, mem_data;
  logic [23:0] mem_addr;
  logic        mem_req, amostra_valid, ocupado, erro_timeout;
  logic [7:0]  amostra;

  assign mem_ack  = resp_ack | stray_ack;
  assign mem_data = stray_ack ? stray_data : resp_data;

  leitor_amostras #(.TIMEOUT_CICLOS(T_MAIN)) dut (
    .clk(clk), .reset(reset), .endereco(endereco), .musica(musica),
    .addr_valid(addr_valid), .mem_ack(mem_ack), .mem_data(mem_data),
    .mem_addr(mem_addr), .mem_req(mem_req), .amostra(amostra),
    .amostra_valid(amostra_valid), .ocupado(ocupado), .erro_timeout(erro_timeout)
  );

  // Short-timeout instance for directed timeout and reset cases
  logic        t_reset, t_av, t_ack;
  logic [21:0] t_end;
  logic [1:0]  t_mus;
  logic [7:0]  t_data, t_amostra;
  logic [23:0] t_addr;
  logic        t_req, t_valid, t_ocup, t_err;

  leitor_amostras #(.TIMEOUT_CICLOS(T_CURTO)) dut_curto (
    .clk(clk), .reset(t_reset), .endereco(t_end), .musica(t_mus),
    .addr_valid(t_av), .mem_ack(t_ack), .mem_data(t_data),
    .mem_addr(t_addr), .mem_req(t_req), .amostra(t_amostra),
    .amostra_valid(t_valid), .ocupado(t_ocup), .erro_timeout(t_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    bit         timeout;
    logic [7:0] data;
    int         req_len;
  } resp_t;

  logic [23:0] exp_addr_q[$];
  resp_t       resp_q[$];
  logic [7:0]  model_amostra = SIL;
  int          ovr_lat  = 0;
  int          ovr_data = -1;

  function automatic logic [7:0] mem_fn(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  // Memory responder: per request picks a latency; beyond the timeout it never acks.
  initial begin : responder
    int lat;
    int n;
    logic [7:0] d;
    resp_t r;
    resp_ack  = 1'b0;
    resp_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        lat = (ovr_lat > 0) ? ovr_lat : int'($urandom_range(1, 10));
        d   = (ovr_data >= 0) ? 8'(ovr_data) : mem_fn(mem_addr);
        r.timeout = (lat > int'(T_MAIN));
        r.data    = d;
        r.req_len = (lat > int'(T_MAIN)) ? int'(T_MAIN) : lat;
        resp_q.push_back(r);
        n = 1;
        while (n < lat && mem_req === 1'b1) begin
          @(negedge clk);
          n++;
        end
        if (n == lat && mem_req === 1'b1) begin
          resp_data = d;
          resp_ack  = 1'b1;
          @(negedge clk);
          resp_ack  = 1'b0;
        end
        while (mem_req === 1'b1) @(negedge clk);
      end
    end
  end

  // Monitor: compares addresses, request lengths and delivered samples against the model.
  initial begin : monitor
    bit    req_prev;
    int    req_len;
    int    ack_edge;
    bit    exp_sil;
    bit    sil_now;
    resp_t r;
    req_prev = 1'b0;
    req_len  = 0;
    ack_edge = -100;
    exp_sil  = 1'b0;
    @(posedge reset);
    forever begin
      @(negedge clk);
      #1;
      sil_now = exp_sil;
      exp_sil = 1'b0;
      if (mem_req && !req_prev) begin
        if (exp_addr_q.size() == 0) check("unexpected_req", 32'(mem_req), 32'(0));
        else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        req_len = 1;
      end else if (mem_req) begin
        req_len++;
      end
      if (!mem_req && req_prev) begin
        if (resp_q.size() > 0) check("req_len", 32'(req_len), 32'(resp_q[0].req_len));
        else check("req_without_resp", 32'(resp_q.size()), 32'(1));
      end
      req_prev = mem_req;
      if (mem_ack && mem_req) ack_edge = cyc + 1;

      if (sil_now) begin
        check("sil_valid", 32'(amostra_valid), 32'(1));
        check("sil_amostra", 32'(amostra), 32'(SIL));
        model_amostra = SIL;
      end
      if (erro_timeout) begin
        if (resp_q.size() == 0) begin
          check("unexpected_timeout", 32'(erro_timeout), 32'(0));
        end else begin
          r = resp_q.pop_front();
          check("timeout_kind", 32'(erro_timeout), 32'(r.timeout));
`ifdef LEITOR_AMOSTRAS_SILENCIO_EN
          exp_sil = 1'b1;
`else
          check("timeout_holds", 32'(amostra), 32'(model_amostra));
`endif
          check("timeout_no_valid", 32'(amostra_valid), 32'(0));
        end
      end
      if (amostra_valid && !sil_now) begin
        if (resp_q.size() == 0) begin
          check("unexpected_valid", 32'(amostra_valid), 32'(0));
        end else begin
          r = resp_q.pop_front();
          check("valid_not_timeout", 32'(r.timeout), 32'(erro_timeout));
          check("amostra", 32'(amostra), 32'(r.data));
          check("valid_latency", 32'(cyc), 32'(ack_edge + 1));
          model_amostra = r.data;
        end
      end
    end
  end

  task automatic pulse(input logic [23:0] a);
    musica     = a[23:22];
    endereco   = a[21:0];
    addr_valid = 1'b1;
    @(negedge clk);
    addr_valid = 1'b0;
    musica     = 2'($urandom);
    endereco   = 22'($urandom);
  endtask

  task automatic esperar_ocioso();
    int quietos = 0;
    int ciclos  = 0;
    while (quietos < 3 && ciclos < 300) begin
      @(negedge clk);
      ciclos++;
      if (!mem_req && !ocupado) quietos++;
      else quietos = 0;
    end
    check("idle_reached", 32'(quietos), 32'(3));
  endtask

  // One request from idle followed by n back-to-back pulses; only the last pulse survives.
  task automatic transacao(input logic [23:0] a, input int n,
                           input logic [23:0] e1, input logic [23:0] e2, input logic [23:0] e3);
    logic [23:0] ex[3];
    ex[0] = e1;
    ex[1] = e2;
    ex[2] = e3;
    exp_addr_q.push_back(a);
    if (n > 0) exp_addr_q.push_back(ex[n-1]);
    pulse(a);
    check("req_rise", 32'(mem_req), 32'(1));
    for (int i = 0; i < n; i++) pulse(ex[i]);
    esperar_ocioso();
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'(0));
    check("resp_q_empty", 32'(resp_q.size()), 32'(0));
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    logic [23:0] a;
    reset = 1'b0; addr_valid = 1'b0; endereco = '0; musica = '0;
    stray_ack = 1'b0; stray_data = '0;
    t_reset = 1'b0; t_av = 1'b0; t_end = '0; t_mus = '0; t_ack = 1'b0; t_data = '0;
    #12;
    check("rst_req", 32'(mem_req), 32'(0));
    check("rst_addr", 32'(mem_addr), 32'(0));
    check("rst_amostra", 32'(amostra), 32'(SIL));
    check("rst_valid", 32'(amostra_valid), 32'(0));
    check("rst_ocupado", 32'(ocupado), 32'(0));
    check("rst_err", 32'(erro_timeout), 32'(0));
    check("t_rst_amostra", 32'(t_amostra), 32'(SIL));
    @(negedge clk);
    reset = 1'b1;
    t_reset = 1'b1;
    @(negedge clk);

    // Basic read: ack in the 4th request cycle
    ovr_lat = 4; ovr_data = 8'h5A;
    transacao({2'd2, 22'h00BB8}, 0, 24'd0, 24'd0, 24'd0);
    check("basic_amostra", 32'(amostra), 32'h5A);

    // Back-to-back 10, 11, 12: 11 must be dropped
    ovr_lat = 5; ovr_data = -1;
    transacao(24'd10, 2, 24'd11, 24'd12, 24'd0);

    // Stray ack while idle
    stray_data = 8'hFF;
    stray_ack  = 1'b1;
    @(negedge clk);
    stray_ack  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_valid", 32'(amostra_valid), 32'(0));
    end
    check("stray_amostra", 32'(amostra), 32'(model_amostra));

    // Random traffic, latencies 1..10 (some exceed the timeout)
    ovr_lat = 0;
    repeat (40) begin
      a = 24'($urandom);
      n = $urandom_range(0, 3);
      transacao(a, n, 24'($urandom), 24'($urandom), 24'($urandom));
    end

    // Short-timeout instance: warm-up read
    t_mus = 2'd1; t_end = 22'h123; t_av = 1'b1;
    @(negedge clk);
    t_av = 1'b0;
    check("t_req_rise", 32'(t_req), 32'(1));
    check("t_addr", 32'(t_addr), 32'h400123);
    t_data = 8'h37; t_ack = 1'b1;
    @(negedge clk);
    t_ack = 1'b0;
    check("t_req_drop", 32'(t_req), 32'(0));
    @(negedge clk);
    check("t_valid", 32'(t_valid), 32'(1));
    check("t_amostra", 32'(t_amostra), 32'h37);
    @(negedge clk);

    // Timeout with no ack
    t_end = 22'h456; t_av = 1'b1;
    @(negedge clk);
    t_av = 1'b0;
    n = 0;
    while (t_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t_req_cycles", 32'(n), 32'(T_CURTO));
    check("t_err", 32'(t_err), 32'(1));
    check("t_err_no_valid", 32'(t_valid), 32'(0));
    @(negedge clk);
    check("t_err_pulse", 32'(t_err), 32'(0));
`ifdef LEITOR_AMOSTRAS_SILENCIO_EN
    check("t_sil_valid", 32'(t_valid), 32'(1));
    check("t_sil_amostra", 32'(t_amostra), 32'(SIL));
`else
    check("t_no_valid", 32'(t_valid), 32'(0));
    check("t_hold_amostra", 32'(t_amostra), 32'h37);
`endif
    repeat (2) @(negedge clk);

    // Reset two cycles into a request
    t_end = 22'h789; t_av = 1'b1;
    @(negedge clk);
    t_av = 1'b0;
    t_data = 8'hC3; t_amostra_pre: begin end
    @(posedge clk);
    @(posedge clk);
    #2 t_reset = 1'b0;
    #1;
    check("t_rst_req", 32'(t_req), 32'(0));
    check("t_rst_amostra2", 32'(t_amostra), 32'(SIL));
    check("t_rst_ocup", 32'(t_ocup), 32'(0));
    check("t_rst_addr", 32'(t_addr), 32'(0));
    repeat (2) @(negedge clk);
    t_reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t_post_req", 32'(t_req), 32'(0));
      check("t_post_valid", 32'(t_valid), 32'(0));
      check("t_post_err", 32'(t_err), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
